fifo_pkt_reader: RTL and testbench
==================================

FIFO_PKT_READER -- requirements
Module: fifo_pkt_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 64, datapath width in bits.
REQ-002 Parameter CTRL_WIDTH, default DATA_WIDTH/8, control width in bits.
REQ-003 Parameter MAX_PKT_WORDS, default 256, longest legal packet including the header word.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 in_dout  input  CTRL_WIDTH+DATA_WIDTH  head word of the upstream fallthrough FIFO, {ctrl,data}; valid whenever in_empty=0.
REQ-007 in_empty  input  1  upstream FIFO empty.
REQ-008 in_rd_en  output  1  pops the upstream FIFO head this cycle.
REQ-009 out_data  output  DATA_WIDTH  downstream data.
REQ-010 out_ctrl  output  CTRL_WIDTH  downstream control.
REQ-011 out_wr  output  1  out_data/out_ctrl valid this cycle.
REQ-012 out_rdy  input  1  downstream can accept a word next cycle (inverse of its nearly_full).
REQ-013 pkt_done  output  1  one-cycle pulse with the eop word's out_wr.
REQ-014 len_err  output  1  one-cycle pulse on an oversize or malformed packet.

Function
REQ-015 in_rd_en SHALL equal !in_empty && out_rdy && !reset, combinationally; it never asserts while in_empty=1.
REQ-016 Latency: a word popped in cycle N SHALL appear on out_data/out_ctrl with out_wr=1 in cycle N+1, unless it is dropped.
REQ-017 Outputs SHALL be registered; out_data/out_ctrl hold their last value when out_wr=0.
REQ-018 Word classes: ctrl==HDR_CTRL (0xFF) is a header; ctrl==0 is payload; any other nonzero ctrl is eop.
REQ-019 FSM states: IDLE, IN_PKT, DROP.
REQ-020 IDLE + header popped: forward the word, set word_cnt=1, go to IN_PKT.
REQ-021 IDLE + non-header popped: drop it (out_wr=0), pulse len_err, stay in IDLE.
REQ-022 IN_PKT + payload popped: forward it and increment word_cnt.
REQ-023 IN_PKT + eop popped: forward it, pulse pkt_done, go to IDLE.
REQ-024 IN_PKT + header popped: treat it as the eop of the current packet (forward it, pulse len_err, go to IDLE).
REQ-025 IN_PKT + popped word would make word_cnt exceed MAX_PKT_WORDS without eop: forward it with ctrl forced to EOP_ERR_CTRL (0x80), pulse len_err, go to DROP.
REQ-026 DROP: pop and discard every word; an eop word returns the FSM to IDLE; a header word is forwarded and enters IN_PKT with word_cnt=1.
REQ-027 word_cnt width SHALL be clog2(MAX_PKT_WORDS)+1 bits; it never wraps inside a packet.
REQ-028 out_rdy deasserting mid-packet SHALL stall popping only; FSM state and word_cnt hold.
REQ-029 Back-to-back packets: an eop followed by a header in the next cycle SHALL stream with no bubble.

Reset
REQ-030 Reset SHALL force state=IDLE, word_cnt=0, out_wr=0, pkt_done=0, len_err=0, and out_data/out_ctrl=0.
REQ-031 Reset SHALL force in_rd_en=0 in the same cycle.
REQ-032 Reset mid-packet SHALL abandon the packet; the first word accepted after reset is evaluated from IDLE.

Configuration
REQ-033 With macro FIFO_PKT_READER_STATS_EN defined, the block SHALL add 32-bit outputs pkt_count and err_count; they are cleared by reset, increment on pkt_done and len_err respectively, and saturate at 0xFFFFFFFF.
REQ-034 Without FIFO_PKT_READER_STATS_EN, these ports and their counters SHALL be absent.

Structure
REQ-035 Shared package pkt_defs_pkg SHALL hold HDR_CTRL, EOP_ERR_CTRL, and the FSM state encoding.
REQ-036 The block SHALL have no sub-modules; the bench instantiates fallthrough_small_fifo upstream of it.

Verification
REQ-037 Header 0xFF, 2 payload words, eop 0x01, out_rdy=1 -> 4 out_wr in consecutive cycles, one cycle after each pop; pkt_done with the 4th word.
REQ-038 Payload word (ctrl=0) arrives in IDLE -> no out_wr, len_err=1 for one cycle, FIFO popped.
REQ-039 MAX_PKT_WORDS=4; header plus 5 payload words then eop -> 4th word out with ctrl=0x80, len_err pulse, remaining words dropped, state returns to IDLE.
REQ-040 out_rdy toggled 1/0 every cycle across a 6-word packet -> in_rd_en only in rdy cycles; all 6 words in order; no loss or duplicate.
REQ-041 Reset asserted after the 2nd word of a packet, then a new packet sent -> outputs zero during reset; new packet forwarded intact.
REQ-042 With FIFO_PKT_READER_STATS_EN: 3 good packets and 1 stray word -> pkt_count=3, err_count=1.

Source files
------------

// File: rtl/pkt_defs_pkg.sv
// Shared packet definitions: control codes and reader FSM encoding.
// Imported by fifo_pkt_reader.
package pkt_defs_pkg;

  localparam logic [7:0] HDR_CTRL     = 8'hFF;
  localparam logic [7:0] EOP_ERR_CTRL = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IN_PKT = 2'd1,
    ST_DROP   = 2'd2
  } state_t;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: dout shows the head word
// whenever empty is low.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   count;
  logic                      do_wr;
  logic                      do_rd;

  assign do_wr       = wr_en && !full;
  assign do_rd       = rd_en && !empty;
  assign dout        = mem[rd_ptr];
  assign empty       = (count == '0);
  assign full        = (count == (MAX_DEPTH_BITS+1)'(DEPTH));
  assign nearly_full = (count >= (MAX_DEPTH_BITS+1)'(DEPTH - 1));

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd) count <= count + 1'b1;
      else if (!do_wr && do_rd) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fifo_pkt_reader.sv
// Pops framed packets from a fallthrough FIFO and forwards them with length checks.
// Optional statistics counters: define FIFO_PKT_READER_STATS_EN.
module fifo_pkt_reader
  import pkt_defs_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
  parameter int MAX_PKT_WORDS = 256
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] in_dout,
  input  logic                             in_empty,
  output logic                             in_rd_en,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  output logic                             pkt_done,
  output logic                             len_err
`ifdef FIFO_PKT_READER_STATS_EN
  ,
  output logic [31:0]                      pkt_count,
  output logic [31:0]                      err_count
`endif
);

  localparam int CNT_W = $clog2(MAX_PKT_WORDS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT_WORDS - 1);
  localparam logic [CTRL_WIDTH-1:0] C_HDR = CTRL_WIDTH'(HDR_CTRL);
  localparam logic [CTRL_WIDTH-1:0] C_ERR = CTRL_WIDTH'(EOP_ERR_CTRL);

  state_t                  state;
  logic [CNT_W-1:0]        word_cnt;
  logic [CTRL_WIDTH-1:0]   in_ctrl;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    is_hdr;
  logic                    is_pay;
  logic                    is_eop;

  assign in_rd_en = !in_empty && out_rdy && !reset;
  assign in_ctrl  = in_dout[CTRL_WIDTH+DATA_WIDTH-1 -: CTRL_WIDTH];
  assign in_data  = in_dout[DATA_WIDTH-1:0];
  assign is_hdr   = (in_ctrl == C_HDR);
  assign is_pay   = (in_ctrl == '0);
  assign is_eop   = !is_hdr && !is_pay;

  // Framing FSM with registered outputs; a stalled cycle holds everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      out_wr   <= 1'b0;
      pkt_done <= 1'b0;
      len_err  <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
    end else begin
      out_wr   <= 1'b0;
      pkt_done <= 1'b0;
      len_err  <= 1'b0;
      if (in_rd_en) begin
        unique case (state)
          ST_IDLE: begin
            if (is_hdr) begin
              out_wr   <= 1'b1;
              out_data <= in_data;
              out_ctrl <= in_ctrl;
              word_cnt <= CNT_W'(1);
              state    <= ST_IN_PKT;
            end else begin
              len_err <= 1'b1;
            end
          end
          ST_IN_PKT: begin
            out_wr   <= 1'b1;
            out_data <= in_data;
            unique case (1'b1)
              is_eop: begin
                out_ctrl <= in_ctrl;
                pkt_done <= 1'b1;
                word_cnt <= '0;
                state    <= ST_IDLE;
              end
              is_hdr: begin
                out_ctrl <= in_ctrl;
                len_err  <= 1'b1;
                word_cnt <= '0;
                state    <= ST_IDLE;
              end
              default: begin
                // Last legal slot taken by payload: the eop can no longer fit.
                if (word_cnt >= CNT_LAST) begin
                  out_ctrl <= C_ERR;
                  len_err  <= 1'b1;
                  word_cnt <= '0;
                  state    <= ST_DROP;
                end else begin
                  out_ctrl <= in_ctrl;
                  word_cnt <= word_cnt + 1'b1;
                end
              end
            endcase
          end
          ST_DROP: begin
            unique case (1'b1)
              is_hdr: begin
                out_wr   <= 1'b1;
                out_data <= in_data;
                out_ctrl <= in_ctrl;
                word_cnt <= CNT_W'(1);
                state    <= ST_IN_PKT;
              end
              is_eop: state <= ST_IDLE;
              default: ;
            endcase
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef FIFO_PKT_READER_STATS_EN
  // Saturating packet and error counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (pkt_done && pkt_count != '1) pkt_count <= pkt_count + 1'b1;
      if (len_err && err_count != '1) err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench for fifo_pkt_reader fed by a fallthrough FIFO.
// Expected outputs come from a word-order reference model queued at push time.
module tb_fifo_pkt_reader;

  localparam int DW  = 64;
  localparam int CW  = 8;
  localparam int MAX = 4;

  typedef struct {
    logic          wr;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          done;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_reset;
  logic [CW+DW-1:0] din;
  logic          wr_en;
  logic [CW+DW-1:0] in_dout;
  logic          in_empty;
  logic          in_rd_en;
  logic          f_full;
  logic          f_nfull;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          out_wr;
  logic          out_rdy;
  logic          pkt_done;
  logic          len_err;
`ifdef FIFO_PKT_READER_STATS_EN
  logic [31:0]   pkt_count;
  logic [31:0]   err_count;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_en = 1'b0;
  logic prev_pop = 1'b0;
  exp_t exp_q[$];
  int   m_st = 0;
  int   m_cnt = 0;
  int   ex_pkts = 0;
  int   ex_errs = 0;
  int   dseq = 0;

  always #5 clk = ~clk;

  fallthrough_small_fifo #(.WIDTH(CW+DW), .MAX_DEPTH_BITS(4)) u_fifo (
    .clk(clk), .reset(fifo_reset), .din(din), .wr_en(wr_en),
    .rd_en(in_rd_en), .dout(in_dout), .full(f_full),
    .nearly_full(f_nfull), .empty(in_empty)
  );

  fifo_pkt_reader #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .MAX_PKT_WORDS(MAX)) dut (
    .clk(clk), .reset(reset), .in_dout(in_dout), .in_empty(in_empty),
    .in_rd_en(in_rd_en), .out_data(out_data), .out_ctrl(out_ctrl),
    .out_wr(out_wr), .out_rdy(out_rdy), .pkt_done(pkt_done),
    .len_err(len_err)
`ifdef FIFO_PKT_READER_STATS_EN
    , .pkt_count(pkt_count), .err_count(err_count)
`endif
  );

  task automatic chk(string tag, logic [71:0] obs, logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic q_push(logic wr, logic [DW-1:0] d, logic [CW-1:0] c,
                        logic done, logic err);
    exp_t e;
    e.wr = wr; e.d = d; e.c = c; e.done = done; e.err = err;
    exp_q.push_back(e);
    if (done) ex_pkts++;
    if (err) ex_errs++;
  endtask

  // Reference: what the word stream must produce, independent of timing.
  task automatic expect_word(logic [CW-1:0] c, logic [DW-1:0] d);
    bit hdr, pay;
    hdr = (c == 8'hFF);
    pay = (c == 8'h00);
    if (m_st == 0) begin
      if (hdr) begin q_push(1, d, c, 0, 0); m_st = 1; m_cnt = 1; end
      else q_push(0, '0, '0, 0, 1);
    end else if (m_st == 1) begin
      if (hdr) begin q_push(1, d, c, 0, 1); m_st = 0; end
      else if (!pay) begin q_push(1, d, c, 1, 0); m_st = 0; end
      else if (m_cnt + 1 == MAX) begin q_push(1, d, 8'h80, 0, 1); m_st = 2; end
      else begin q_push(1, d, c, 0, 0); m_cnt++; end
    end else begin
      if (hdr) begin q_push(1, d, c, 0, 0); m_st = 1; m_cnt = 1; end
      else if (!pay) m_st = 0;
    end
  endtask

  task automatic push(logic [CW-1:0] c);
    logic [DW-1:0] d;
    dseq++;
    d = 64'hD00D_0000_0000_0000 | 64'(dseq * 17);
    expect_word(c, d);
    din   = {c, d};
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain(string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk({tag, "_drain"}, 72'(exp_q.size()), 72'(0));
  endtask

  always @(posedge clk) prev_pop <= in_rd_en;

  // Output monitor: every output event is matched against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      chk("rd_en_rule", 72'(in_rd_en), 72'(!in_empty && out_rdy && !reset));
      if (out_wr) chk("latency", 72'(prev_pop), 72'(1));
      if (out_wr || pkt_done || len_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 72'({out_wr, pkt_done, len_err}), 72'(0));
        end else begin
          e = exp_q.pop_front();
          chk("out_wr", 72'(out_wr), 72'(e.wr));
          chk("pkt_done", 72'(pkt_done), 72'(e.done));
          chk("len_err", 72'(len_err), 72'(e.err));
          if (e.wr) begin
            chk("out_data", 72'(out_data), 72'(e.d));
            chk("out_ctrl", 72'(out_ctrl), 72'(e.c));
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; fifo_reset = 1'b1;
    out_rdy = 1'b0; wr_en = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_wr", 72'(out_wr), 72'(0));
    chk("rst_done", 72'(pkt_done), 72'(0));
    chk("rst_err", 72'(len_err), 72'(0));
    chk("rst_data", 72'(out_data), 72'(0));
    chk("rst_ctrl", 72'(out_ctrl), 72'(0));
    chk("rst_rd_en", 72'(in_rd_en), 72'(0));
    reset = 1'b0; fifo_reset = 1'b0;
    chk_en = 1'b1;

    // Two back-to-back packets preloaded, then streamed.
    push(8'hFF); push(8'h00); push(8'h00); push(8'h01);
    push(8'hFF); push(8'h00); push(8'h02);
    out_rdy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("stream_no_bubble", 72'(out_wr), 72'(1));
    end
    drain("basic");

    // Stray payload in IDLE.
    push(8'h00);
    drain("stray");

    // Oversize packet, then a good packet.
    push(8'hFF);
    for (int i = 0; i < 5; i++) push(8'h00);
    push(8'h01);
    push(8'hFF); push(8'h03);
    drain("oversize");

    // Header inside a packet, then an eop that is now stray.
    push(8'hFF); push(8'h00); push(8'hFF); push(8'h04);
    drain("hdr_in_pkt");

    // Backpressure toggling across 6 words.
    out_rdy = 1'b0;
    push(8'hFF); push(8'h00); push(8'h05);
    push(8'hFF); push(8'h00); push(8'h06);
    for (int i = 0; i < 16; i++) begin
      out_rdy = ~out_rdy;
      @(negedge clk);
    end
    out_rdy = 1'b1;
    drain("toggle");

    // Reset mid-packet with a word waiting upstream.
    push(8'hFF); push(8'h00);
    drain("pre_reset");
    reset = 1'b1;
    m_st = 0; m_cnt = 0; ex_pkts = 0; ex_errs = 0;
    push(8'h00);
    chk("rst_mid_wr", 72'(out_wr), 72'(0));
    chk("rst_mid_data", 72'(out_data), 72'(0));
    chk("rst_mid_ctrl", 72'(out_ctrl), 72'(0));
    chk("rst_mid_rd_en", 72'(in_rd_en), 72'(0));
    @(negedge clk);
    reset = 1'b0;
    push(8'hFF); push(8'h00); push(8'h00); push(8'h07);
    drain("post_reset");

    // Two more good packets for the counters.
    push(8'hFF); push(8'h08);
    push(8'hFF); push(8'h00); push(8'h09);
    drain("final");
`ifdef FIFO_PKT_READER_STATS_EN
    chk("pkt_count", 72'(pkt_count), 72'(ex_pkts));
    chk("err_count", 72'(err_count), 72'(ex_errs));
`endif
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
